// File: rtl/pixel_fb_writer.sv
// Pixel frame-buffer writer: RGB888 -> RGB444, raster addressing with clipping,
// full-buffer clear sweep, and a small FIFO to hold pixels arriving during the sweep.
module pixel_fb_writer #(
  parameter int          FB_WIDTH    = 320,
  parameter int          FB_HEIGHT   = 240,
  parameter int          ADDR_W      = 17,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pix_r,
  input  logic [7:0]        pix_g,
  input  logic [7:0]        pix_b,
  input  logic              pix_valid,
  input  logic [15:0]       img_height,
  input  logic [15:0]       img_width,
  input  logic              dim_valid,
  input  logic              clear_req,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]       PTR_ONE  = (PW+1)'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [31:0]       FBW      = 32'(FB_WIDTH);
  localparam logic [31:0]       FBH      = 32'(FB_HEIGHT);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic              dim_latched_q, dim_latched_d;
  logic [15:0]       w_q, w_d, h_q, h_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic [31:0]       row_base_q, row_base_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [23:0]       rd_data;

  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [11:0]       fb_wdata_q, fb_wdata_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic empty, full, pop, push, drop;
  logic dims_ok, last_x, last_y, in_fb;

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop     = !empty && ((state_q == RUN) || (state_q == DONE));
  assign push    = pix_valid && (!full || pop);
  assign drop    = pix_valid && full && !pop;
  assign rd_data = fifo_mem[rd_ptr_q[PW-1:0]];

  assign dims_ok = (w_q != 16'd0) && (h_q != 16'd0);
  assign last_x  = (x_q == w_q - 16'd1);
  assign last_y  = (y_q == h_q - 16'd1);
  assign in_fb   = ({16'd0, x_q} < FBW) && ({16'd0, y_q} < FBH);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= {pix_r, pix_g, pix_b};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_comb begin
    state_d       = state_q;
    dim_latched_d = dim_latched_q;
    w_d           = w_q;
    h_d           = h_q;
    x_d           = x_q;
    y_d           = y_q;
    row_base_d    = row_base_q;
    clr_addr_d    = clr_addr_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_wdata_d    = fb_wdata_q;
    busy_d        = 1'b0;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q | drop;

    if (!dim_latched_q && dim_valid) begin
      w_d           = img_width;
      h_d           = img_height;
      dim_latched_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else if (dim_latched_q) begin
          state_d = RUN;
        end
      end
      CLEAR: begin
        fb_we_d    = 1'b1;
        fb_wdata_d = CLEAR_COLOR;
        fb_addr_d  = clr_addr_q;
        busy_d     = 1'b1;
        if (clr_addr_q == CLR_LAST) begin
          clr_addr_d = '0;
          state_d    = dim_latched_q ? RUN : IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      RUN: begin
        // Zero-sized images swallow pixels without touching the counters.
        if (pop && dims_ok) begin
          fb_addr_d  = ADDR_W'(row_base_q + {16'd0, x_q});
          fb_wdata_d = {rd_data[23:20], rd_data[15:12], rd_data[7:4]};
          fb_we_d    = in_fb;
          if (last_x) begin
            x_d        = 16'd0;
            y_d        = y_q + 16'd1;
            row_base_d = row_base_q + FBW;
          end else begin
            x_d = x_q + 16'd1;
          end
          if (last_x && last_y) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        if (clear_req) begin
          state_d       = CLEAR;
          clr_addr_d    = '0;
          x_d           = 16'd0;
          y_d           = 16'd0;
          row_base_d    = '0;
          dim_latched_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dim_latched_q <= 1'b0;
      w_q           <= '0;
      h_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      row_base_q    <= '0;
      clr_addr_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dim_latched_q <= dim_latched_d;
      w_q           <= w_d;
      h_q           <= h_d;
      x_q           <= x_d;
      y_q           <= y_d;
      row_base_q    <= row_base_d;
      clr_addr_q    <= clr_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_wdata_q    <= fb_wdata_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer: random pixels checked against a
// raster-order reference model of expected writes.
module tb_pixel_fb_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
  logic        pix_valid = 1'b0;
  logic [15:0] img_height = '0, img_width = '0;
  logic        dim_valid = 1'b0, clear_req = 1'b0;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [11:0] fb_wdata;
  logic        busy, frame_done, overflow;

  pixel_fb_writer dut (
    .clk(clk), .reset(reset), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .img_height(img_height), .img_width(img_width),
    .dim_valid(dim_valid), .clear_req(clear_req), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Visible event = {we, addr, data, frame_done}
  typedef struct {
    int          cyc;
    logic [30:0] v;
  } ev_t;

  ev_t         evq[$];
  logic [30:0] expq[$];
  logic [23:0] pix_q[$];
  int          cyc = 0;
  int          clr_seen = 0, clr_bad = 0, last_busy_cyc = 0;
  int          n_pass = 0, n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (!fb_we || fb_addr != 17'(clr_seen) || fb_wdata != 12'h000) clr_bad <= clr_bad + 1;
        clr_seen      <= clr_seen + 1;
        last_busy_cyc <= cyc;
      end else if (fb_we || frame_done) begin
        evq.push_back('{cyc, {fb_we, fb_addr, fb_wdata, frame_done}});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pix_valid = 1'b0; dim_valid = 1'b0; clear_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    evq.delete(); pix_q.delete();
  endtask

  task automatic set_dims(input int w, input int h);
    img_width = 16'(w); img_height = 16'(h); dim_valid = 1'b1;
  endtask

  task automatic send_pix(input logic [23:0] p, input int gap);
    {pix_r, pix_g, pix_b} = p;
    pix_valid = 1'b1;
    pix_q.push_back(p);
    tick();
    pix_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Raster model: pixel i lands at (i % W, i / W); pixels after the frame are discarded.
  task automatic build_exp(input int w, input int h);
    int x, y;
    logic we, dn;
    logic [23:0] p;
    expq.delete();
    if (w == 0 || h == 0) return;
    for (int i = 0; i < pix_q.size() && i < w * h; i++) begin
      x = i % w; y = i / w; p = pix_q[i];
      we = (x < 320) && (y < 240);
      dn = (i == w * h - 1);
      if (we || dn) expq.push_back({we, 17'(y * 320 + x), p[23:20], p[15:12], p[7:4], dn});
    end
  endtask

  task automatic wait_events(input int budget);
    for (int t = 0; t < budget && evq.size() < expq.size(); t++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_chk++; if (fb_we !== 1'b0) $display("FAIL rst_we got %b want 0", fb_we); else n_pass++;
    n_chk++; if (fb_addr !== 17'd0) $display("FAIL rst_addr got %h want 0", fb_addr); else n_pass++;
    n_chk++; if (fb_wdata !== 12'd0) $display("FAIL rst_wdata got %h want 0", fb_wdata); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_done got %b want 0", frame_done); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_basic_frame();
    do_reset();
    set_dims(3, 2);
    repeat (3) tick();
    for (int i = 0; i < 6; i++) send_pix(24'hF0801F, $urandom_range(0, 2));
    build_exp(3, 2);
    wait_events(200);
    n_chk++; if (evq.size() !== expq.size()) $display("FAIL basic_count got %0d want %0d", evq.size(), expq.size()); else n_pass++;
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      n_chk++; if (evq[i].v !== expq[i]) $display("FAIL basic_ev%0d got %h want %h", i, evq[i].v, expq[i]); else n_pass++;
    end
    // Frame is complete: a further pixel must be swallowed.
    send_pix(24'hFFFFFF, 0);
    repeat (6) tick();
    n_chk++; if (evq.size() !== 6) $display("FAIL basic_done_discard got %0d events want 6", evq.size()); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL basic_ovf got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_clip();
    do_reset();
    set_dims(322, 1);
    repeat (3) tick();
    for (int i = 0; i < 322; i++) send_pix(24'($urandom), $urandom_range(0, 1));
    build_exp(322, 1);
    wait_events(2000);
    n_chk++; if (evq.size() !== expq.size()) $display("FAIL clip_count got %0d want %0d", evq.size(), expq.size()); else n_pass++;
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      n_chk++; if (evq[i].v !== expq[i]) $display("FAIL clip_ev%0d got %h want %h", i, evq[i].v, expq[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int k;
    do_reset();
    set_dims(8, 1);
    repeat (3) tick();
    k = cyc;
    for (int i = 0; i < 8; i++) send_pix(24'($urandom), 0);
    build_exp(8, 1);
    wait_events(100);
    n_chk++; if (evq.size() !== expq.size()) $display("FAIL b2b_count got %0d want %0d", evq.size(), expq.size()); else n_pass++;
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      n_chk++; if (evq[i].v !== expq[i]) $display("FAIL b2b_ev%0d got %h want %h", i, evq[i].v, expq[i]); else n_pass++;
      n_chk++; if (evq[i].cyc !== k + 2 + i) $display("FAIL b2b_cyc%0d got %0d want %0d", i, evq[i].cyc, k + 2 + i); else n_pass++;
    end
  endtask

  task automatic test_clear_overflow();
    do_reset();
    set_dims(4, 4);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 17; i++) send_pix(24'($urandom), $urandom_range(0, 3));
    n_chk++; if (overflow !== 1'b1) $display("FAIL clr_ovf_set got %b want 1", overflow); else n_pass++;
    pix_q.delete(16);
    for (int t = 0; t < 80000 && (busy || clr_seen == 0); t++) tick();
    build_exp(4, 4);
    wait_events(200);
    n_chk++; if (clr_seen !== 76800) $display("FAIL clr_writes got %0d want 76800", clr_seen); else n_pass++;
    n_chk++; if (clr_bad !== 0) $display("FAIL clr_bad_writes got %0d want 0", clr_bad); else n_pass++;
    n_chk++; if (evq.size() !== expq.size()) $display("FAIL clr_count got %0d want %0d", evq.size(), expq.size()); else n_pass++;
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      n_chk++; if (evq[i].v !== expq[i]) $display("FAIL clr_ev%0d got %h want %h", i, evq[i].v, expq[i]); else n_pass++;
    end
    if (evq.size() > 0) begin
      n_chk++; if (evq[0].cyc !== last_busy_cyc + 1) $display("FAIL clr_first_cyc got %0d want %0d", evq[0].cyc, last_busy_cyc + 1); else n_pass++;
    end
    n_chk++; if (overflow !== 1'b1) $display("FAIL clr_ovf_sticky got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_dims(3, 2);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) send_pix(24'($urandom), 0);
    repeat (2) tick();
    reset = 1'b1; dim_valid = 1'b0;
    tick();
    n_chk++; if ({fb_we, fb_addr, fb_wdata, busy, frame_done, overflow} !== 33'd0)
      $display("FAIL mid_rst_outputs got %h want 0", {fb_we, fb_addr, fb_wdata, busy, frame_done, overflow}); else n_pass++;
    set_dims(2, 1);
    tick();
    reset = 1'b0;
    evq.delete(); pix_q.delete();
    repeat (3) tick();
    for (int i = 0; i < 2; i++) send_pix(24'($urandom), 1);
    build_exp(2, 1);
    wait_events(100);
    n_chk++; if (evq.size() !== expq.size()) $display("FAIL mid_count got %0d want %0d", evq.size(), expq.size()); else n_pass++;
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      n_chk++; if (evq[i].v !== expq[i]) $display("FAIL mid_ev%0d got %h want %h", i, evq[i].v, expq[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_clip();
    test_back_to_back();
    test_clear_overflow();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
